// File: rtl/frame_move_scheduler_pkg.sv
// Shared constants and types for the frame move scheduler: key bit map, FSM states, speed reloads.
package frame_move_scheduler_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_FIRE  = 4;
  localparam int KEY_W     = 5;

  localparam int V_ACTIVE_DEF = 480;

  typedef logic [KEY_W-1:0] keys_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNAP    = 3'd1,
    ST_SERVE_A = 3'd2,
    ST_WAIT_A  = 3'd3,
    ST_SERVE_B = 3'd4,
    ST_WAIT_B  = 3'd5
  } sched_state_t;

  // Divider reload is N-1, where N is the number of frames per move.
  function automatic logic [2:0] speed_reload(input logic [1:0] speed);
    case (speed)
      2'b00:   return 3'd7;
      2'b01:   return 3'd3;
      2'b10:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_move_scheduler_if.sv
// Move command handshake toward the draw datapath; req/player/dir hold until ack or timeout.
interface frame_move_scheduler_if;
  import frame_move_scheduler_pkg::*;

  logic  Move_Req_Out;
  logic  Move_Player_Out;
  keys_t Move_Dir_Out;
  logic  Move_Ack_In;

  modport master (output Move_Req_Out, Move_Player_Out, Move_Dir_Out, input Move_Ack_In);
  modport slave  (input Move_Req_Out, Move_Player_Out, Move_Dir_Out, output Move_Ack_In);
endinterface

// File: rtl/frame_move_scheduler_key_cleaner.sv
// Per-player key cleanup: cancels opposite directions, turns fire into a rising edge between snapshots.
// Combinational output; fire history only advances on snap.
module frame_move_scheduler_key_cleaner
  import frame_move_scheduler_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  snap,
  input  keys_t keys,
  output keys_t clean
);

  logic prev_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_fire <= 1'b0;
    end else if (snap) begin
      prev_fire <= keys[KEY_FIRE];
    end
  end

  always_comb begin
    clean = keys;
    if (keys[KEY_UP] && keys[KEY_DOWN]) begin
      clean[KEY_UP]   = 1'b0;
      clean[KEY_DOWN] = 1'b0;
    end
    if (keys[KEY_LEFT] && keys[KEY_RIGHT]) begin
      clean[KEY_LEFT]  = 1'b0;
      clean[KEY_RIGHT] = 1'b0;
    end
    clean[KEY_FIRE] = keys[KEY_FIRE] & ~prev_fire;
  end

endmodule

// File: rtl/frame_move_scheduler.sv
// Frame tick, speed divider and per-player move command sequencing with round-robin order.
// Tick one cycle after row/col match; commands wait for ack or ACK_TIMEOUT cycles each.
module frame_move_scheduler
  import frame_move_scheduler_pkg::*;
#(
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int ACK_TIMEOUT = 64,
  parameter int FCNT_W      = 8
) (
  input  logic                  Master_Clock_In,
  input  logic                  Reset_In,
  input  logic [9:0]            Val_Row_In,
  input  logic [9:0]            Val_Col_In,
  input  keys_t                 P1_Keys_In,
  input  keys_t                 P2_Keys_In,
  input  logic [1:0]            MoveSpeed_In,
  frame_move_scheduler_if.master move_if,
  output logic                  Frame_Tick_Out,
  output logic [FCNT_W-1:0]     Frame_Count_Out,
  output logic                  Overrun_Out
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  sched_state_t    state, state_nxt;
  logic            tick_det, move_frame, snap, wait_done;
  logic [2:0]      div_q;
  logic            rr_q, issued_q;
  keys_t           vec_p1, vec_p2, clean_p1, clean_p2, vec_a, vec_b;
  logic [TO_W-1:0] wait_cnt;

  assign tick_det   = (Val_Row_In == 10'(V_ACTIVE)) && (Val_Col_In == 10'd0);
  assign move_frame = Frame_Tick_Out && (div_q == 3'd0);
  assign snap       = (state == ST_SNAP);
  assign vec_a      = rr_q ? vec_p2 : vec_p1;
  assign vec_b      = rr_q ? vec_p1 : vec_p2;
  assign wait_done  = move_if.Move_Ack_In || (wait_cnt == TO_W'(ACK_TIMEOUT - 1));

  frame_move_scheduler_key_cleaner u_clean_p1 (
    .clk(Master_Clock_In), .rst(Reset_In), .snap(snap), .keys(P1_Keys_In), .clean(clean_p1)
  );
  frame_move_scheduler_key_cleaner u_clean_p2 (
    .clk(Master_Clock_In), .rst(Reset_In), .snap(snap), .keys(P2_Keys_In), .clean(clean_p2)
  );

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      Frame_Tick_Out  <= 1'b0;
      Frame_Count_Out <= '0;
      div_q           <= 3'd0;
      Overrun_Out     <= 1'b0;
    end else begin
      Frame_Tick_Out <= tick_det;
      if (tick_det) Frame_Count_Out <= Frame_Count_Out + FCNT_W'(1);
      if (Frame_Tick_Out) div_q <= (div_q == 3'd0) ? speed_reload(MoveSpeed_In) : div_q - 3'd1;
      if (move_frame && (state != ST_IDLE)) Overrun_Out <= 1'b1;
    end
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (move_frame) state_nxt = ST_SNAP;
      ST_SNAP:    state_nxt = ST_SERVE_A;
      ST_SERVE_A: state_nxt = (vec_a != '0) ? ST_WAIT_A : ST_SERVE_B;
      ST_WAIT_A:  if (wait_done) state_nxt = ST_SERVE_B;
      ST_SERVE_B: state_nxt = (vec_b != '0) ? ST_WAIT_B : ST_IDLE;
      ST_WAIT_B:  if (wait_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Request is live only in the WAIT states, so it always drops for a cycle between commands.
  always_comb begin
    move_if.Move_Req_Out    = 1'b0;
    move_if.Move_Player_Out = 1'b0;
    move_if.Move_Dir_Out    = '0;
    case (state)
      ST_WAIT_A: begin
        move_if.Move_Req_Out    = 1'b1;
        move_if.Move_Player_Out = rr_q;
        move_if.Move_Dir_Out    = vec_a;
      end
      ST_WAIT_B: begin
        move_if.Move_Req_Out    = 1'b1;
        move_if.Move_Player_Out = ~rr_q;
        move_if.Move_Dir_Out    = vec_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      vec_p1   <= '0;
      vec_p2   <= '0;
      rr_q     <= 1'b0;
      issued_q <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (snap) begin
        vec_p1   <= clean_p1;
        vec_p2   <= clean_p2;
        issued_q <= 1'b0;
      end else if ((state_nxt == ST_WAIT_A) || (state_nxt == ST_WAIT_B)) begin
        issued_q <= 1'b1;
      end
      wait_cnt <= ((state == ST_WAIT_A) || (state == ST_WAIT_B)) ? wait_cnt + TO_W'(1) : '0;
      if (((state == ST_SERVE_B) || (state == ST_WAIT_B)) && (state_nxt == ST_IDLE) && issued_q)
        rr_q <= ~rr_q;
    end
  end

endmodule

// File: tb/tb_frame_move_scheduler.sv
// Randomized and directed bench for frame_move_scheduler against a frame-level command model.
`timescale 1ns/1ps
module tb_frame_move_scheduler;
  import frame_move_scheduler_pkg::*;

  localparam int V_ACT = 480;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] row, col;
  logic [4:0] p1, p2;
  logic [1:0] speed;
  logic       tick;
  logic [7:0] fcnt;
  logic       ovr;

  frame_move_scheduler_if mif ();

  frame_move_scheduler #(.V_ACTIVE(V_ACT), .ACK_TIMEOUT(TMO), .FCNT_W(8)) dut (
    .Master_Clock_In(clk), .Reset_In(rst), .Val_Row_In(row), .Val_Col_In(col),
    .P1_Keys_In(p1), .P2_Keys_In(p2), .MoveSpeed_In(speed), .move_if(mif),
    .Frame_Tick_Out(tick), .Frame_Count_Out(fcnt), .Overrun_Out(ovr)
  );

  always #20 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Observed commands: {player, dir} captured when req rises; request lengths in cycles.
  logic [5:0] cap_q[$];
  int         len_q[$];
  int         unstable = 0;
  int         req_len = 0;
  logic       prev_req = 1'b0;
  logic [5:0] last_cmd = '0;

  always @(negedge clk) begin
    if (mif.Move_Req_Out === 1'b1) begin
      if (!prev_req) begin
        cap_q.push_back({mif.Move_Player_Out, mif.Move_Dir_Out});
        req_len = 0;
      end else if ({mif.Move_Player_Out, mif.Move_Dir_Out} !== last_cmd) begin
        unstable++;
      end
      last_cmd = {mif.Move_Player_Out, mif.Move_Dir_Out};
      req_len++;
      prev_req = 1'b1;
    end else begin
      if (prev_req) len_q.push_back(req_len);
      prev_req = 1'b0;
    end
  end

  // Datapath stand-in: acks ack_delay cycles after req rises (negative = never).
  int ack_delay = 0;
  bit spurious = 1'b0;
  int hold = 0;

  always @(negedge clk) begin
    if (mif.Move_Req_Out !== 1'b1) begin
      hold = 0;
      mif.Move_Ack_In = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    end else begin
      mif.Move_Ack_In = (ack_delay >= 0) && (hold == ack_delay);
      hold++;
    end
  end

  // Reference model: move frames are spaced N = 8 >> speed ticks apart, N taken at the move tick.
  int         m_ticks, m_next_move;
  bit         m_rr, m_ovr;
  bit [1:0]   m_pf;
  logic [5:0] exp_q[$];

  function automatic logic [4:0] clean_keys(input logic [4:0] k, input bit pf);
    logic [4:0] c;
    c = k;
    if (k[0] && k[3]) begin c[0] = 1'b0; c[3] = 1'b0; end
    if (k[1] && k[2]) begin c[1] = 1'b0; c[2] = 1'b0; end
    c[4] = k[4] && !pf;
    return c;
  endfunction

  function automatic void model_reset();
    m_ticks = 0; m_next_move = 0; m_rr = 1'b0; m_ovr = 1'b0; m_pf = 2'b00;
    exp_q.delete(); cap_q.delete(); len_q.delete(); unstable = 0;
  endfunction

  task automatic model_tick(input bit busy);
    logic [4:0] c [2];
    bit any;
    int pl;
    if (m_ticks == m_next_move) begin
      m_next_move = m_ticks + (8 >> speed);
      if (busy) begin
        m_ovr = 1'b1;
      end else begin
        c[0] = clean_keys(p1, m_pf[0]);
        c[1] = clean_keys(p2, m_pf[1]);
        m_pf = {p2[4], p1[4]};
        any = 1'b0;
        for (int k = 0; k < 2; k++) begin
          pl = int'(m_rr) ^ k;
          if (c[pl] != 5'd0) begin
            exp_q.push_back({1'(pl), c[pl]});
            any = 1'b1;
          end
        end
        if (any) m_rr = !m_rr;
      end
    end
    m_ticks++;
  endtask

  task automatic idle_rowcol();
    row = 10'($urandom_range(0, V_ACT - 1));
    col = 10'($urandom_range(1, 799));
  endtask

  task automatic frame(input int gap, input bit busy);
    @(posedge clk); #1; row = 10'(V_ACT); col = 10'd0;
    model_tick(busy);
    @(posedge clk); #1; idle_rowcol();
    repeat (gap) begin @(posedge clk); #1; idle_rowcol(); end
  endtask

  task automatic check_cmds(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check({tag, "_cmd"}, cap_q[i], exp_q[i]);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_fcnt"}, fcnt, m_ticks % 256);
    check({tag, "_ovr"}, ovr, m_ovr);
    cap_q.delete(); exp_q.delete(); len_q.delete(); unstable = 0;
  endtask

  initial begin
    rst = 1'b1; row = 10'd0; col = 10'd1; p1 = '0; p2 = '0; speed = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", mif.Move_Req_Out, 0);
    check("rst_tick", tick, 0);
    check("rst_fcnt", fcnt, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    model_reset();

    // Reset held 3 cycles while a request sits in WAIT_A.
    speed = 2'b11; p1 = 5'b00100; p2 = '0; ack_delay = -1;
    frame(5, 1'b0);
    @(negedge clk); check("pre_rst_req", mif.Move_Req_Out, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req", mif.Move_Req_Out, 0);
    check("rst_mid_fcnt", fcnt, 0);
    check("rst_mid_ovr", ovr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    ack_delay = 0;
    frame(20, 1'b0);
    check_cmds("post_rst");

    // Speed 00 over 16 frames, tick timing checked on the first one.
    speed = 2'b00; p1 = 5'b00001; p2 = '0;
    @(posedge clk); #1; row = 10'(V_ACT); col = 10'd0; model_tick(1'b0);
    @(negedge clk); check("tick_early", tick, 0);
    @(posedge clk); #1; idle_rowcol();
    @(negedge clk); check("tick_high", tick, 1); check("fcnt_on_tick", fcnt, m_ticks);
    @(negedge clk); check("tick_single", tick, 0);
    repeat (20) @(posedge clk);
    for (int f = 0; f < 15; f++) frame(20, 1'b0);
    check("spd0_reqs", cap_q.size(), 2);
    if (cap_q.size() > 0) check("spd0_first", cap_q[0], 6'b000001);
    check_cmds("spd0");

    // Every frame, both players, ack after 3 cycles: order alternates per frame.
    speed = 2'b11; p1 = 5'b00100; p2 = 5'b01000; ack_delay = 3;
    for (int f = 0; f < 4; f++) frame(30, 1'b0);
    check("spd3_lens", len_q.size(), 8);
    foreach (len_q[i]) check("spd3_len", len_q[i], 4);
    check_cmds("spd3");

    // Cancelled directions produce no request; fire only on its rising edge.
    ack_delay = 0; p1 = 5'b01001; p2 = '0;
    for (int f = 0; f < 3; f++) frame(20, 1'b0);
    check("cancel_none", cap_q.size(), 0);
    check_cmds("cancel");
    p1 = 5'b10000;
    for (int f = 0; f < 3; f++) frame(20, 1'b0);
    check_cmds("fire");

    // No ack: each request times out after ACK_TIMEOUT cycles.
    ack_delay = -1; p1 = 5'b00010; p2 = 5'b00001;
    for (int f = 0; f < 2; f++) frame(150, 1'b0);
    check("tmo_lens", len_q.size(), 4);
    foreach (len_q[i]) check("tmo_len", len_q[i], TMO);
    check_cmds("tmo");

    // Move tick while busy: overrun, no snapshot of the changed keys.
    p1 = 5'b00100; p2 = '0;
    frame(10, 1'b0);
    p2 = 5'b00001;
    frame(150, 1'b1);
    check("ovr_set", ovr, 1);
    check_cmds("ovr");
    frame(150, 1'b0);
    check_cmds("ovr_after");

    // Randomized frames with speed changes, random keys, ack delays and spurious acks.
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    spurious = 1'b1;
    for (int f = 0; f < 40; f++) begin
      speed = 2'($urandom_range(0, 3));
      p1 = 5'($urandom_range(0, 31));
      p2 = 5'($urandom_range(0, 31));
      ack_delay = $urandom_range(0, 4);
      frame(40, 1'b0);
    end
    check_cmds("rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
